// File: rtl/ascii_stream_pkg.sv
// Shared types, ASCII constants and helpers for the ASCII decimal stream.
// Optional down counting is enabled by defining ASCII_STREAM_DOWN_EN.
package ascii_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/ascii_digit_cell.sv
// One ASCII decimal digit with its carry/borrow step.
// Borrow logic exists only when ASCII_STREAM_DOWN_EN is defined.
module ascii_digit_cell
    import ascii_stream_pkg::*;
(
    input  logic [7:0] digit,
    input  logic       down,
    input  logic       lower_sat,
    output logic [7:0] next_digit,
    output logic       sat
);

`ifdef ASCII_STREAM_DOWN_EN
    // Saturation test and step in the selected direction
    always_comb begin
        next_digit = digit;
        sat        = down ? (digit == ASCII_ZERO) : (digit == ASCII_NINE);
        if (lower_sat) begin
            if (sat)
                next_digit = down ? ASCII_NINE : ASCII_ZERO;
            else if (down)
                next_digit = digit - 8'd1;
            else
                next_digit = digit + 8'd1;
        end
    end
`else
    logic down_unused;
    assign down_unused = down;

    // Up-only saturation test and increment
    always_comb begin
        next_digit = digit;
        sat        = (digit == ASCII_NINE);
        if (lower_sat) begin
            if (sat)
                next_digit = ASCII_ZERO;
            else
                next_digit = digit + 8'd1;
        end
    end
`endif

endmodule

// File: rtl/ascii_dec_stream.sv
// ASCII decimal sequence generator with valid/ready output and abort.
// Define ASCII_STREAM_DOWN_EN to honour the down port.
module ascii_dec_stream
    import ascii_stream_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int CW     = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [8*DIGITS-1:0]   start_data,
    input  logic [CW-1:0]         length,
    input  logic                  down,
    input  logic                  abort,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*DIGITS-1:0]   value,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap,
    output logic                  load_err
);

    localparam int W = 8 * DIGITS;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   remaining;
    logic            dir;
    logic [W-1:0]    load_val;
    logic            load_bad;
    logic [W-1:0]    step_val;
    logic [DIGITS:0] chain;
    logic [DIGITS-1:0] sat;
    logic            accept;
    logic            hs;
    logic            all_sat;

    assign accept    = (state == IDLE) & start & ~abort;
    assign hs        = (state == RUN) & out_ready & ~abort;
    assign all_sat   = chain[DIGITS];
    assign out_valid = (state == RUN);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // Sanitise the loaded string: non-digit bytes become "0"
    always_comb begin
        load_val = '0;
        load_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (is_digit(start_data[8*i +: 8])) begin
                load_val[8*i +: 8] = start_data[8*i +: 8];
            end else begin
                load_val[8*i +: 8] = ASCII_ZERO;
                load_bad = 1'b1;
            end
        end
    end

    assign chain[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            ascii_digit_cell u_cell (
                .digit      (value[8*g +: 8]),
                .down       (dir),
                .lower_sat  (chain[g]),
                .next_digit (step_val[8*g +: 8]),
                .sat        (sat[g])
            );
            assign chain[g+1] = chain[g] & sat[g];
        end
    endgenerate

    // Next-state decode; abort overrides every transition
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = (length == '0) ? DONE : RUN;
            end
            RUN: begin
                if (out_ready && remaining == CW'(1))
                    state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort)
            state_nx = IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Value, burst counter, wrap pulse and sticky load error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value     <= {DIGITS{ASCII_ZERO}};
            remaining <= '0;
            wrap      <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            wrap <= hs & all_sat;
            if (accept) begin
                value     <= load_val;
                remaining <= length;
                load_err  <= load_bad;
            end else if (hs) begin
                value     <= step_val;
                remaining <= remaining - CW'(1);
            end
        end
    end

`ifdef ASCII_STREAM_DOWN_EN
    // Direction is captured with the start request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            dir <= 1'b0;
        else if (accept)
            dir <= down;
    end
`else
    logic down_unused;
    assign down_unused = down;
    assign dir = 1'b0;
`endif

endmodule

// File: tb/tb_ascii_dec_stream.sv
// Directed self-checking bench for ascii_dec_stream (DIGITS=8).
// Covers load, carry, wrap, backpressure, load error, abort and reset.
module tb_ascii_dec_stream;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [63:0] start_data;
    logic [31:0] length;
    logic        down;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] value;
    logic        busy;
    logic        done;
    logic        wrap;
    logic        load_err;

    int n_tests;
    int n_fail;
    int hs_cnt;

    ascii_dec_stream #(.DIGITS(8), .CW(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_data (start_data),
        .length     (length),
        .down       (down),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .value      (value),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completed handshakes at the active edge
    always @(posedge clk)
        if (reset_n && out_valid && out_ready)
            hs_cnt++;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [63:0] d, input int unsigned len,
                        input logic dn);
        start      = 1'b1;
        start_data = d;
        length     = len;
        down       = dn;
        step();
        start      = 1'b0;
        start_data = "XXXXXXXX";
        length     = 32'd7;
        down       = ~dn;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        hs_cnt    = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        start_data = '0;
        length    = '0;
        down      = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_value", value, "00000000");
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_flags", {done, wrap, load_err}, 3'b000);
        reset_n = 1'b1;
        step();

        // Carry across two digits
        kick("00000098", 3, 1'b0);
        check("c_v0", value, "00000098");
        check("c_valid", out_valid, 1'b1);
        check("c_busy", busy, 1'b1);
        step();
        check("c_v1", value, "00000099");
        step();
        check("c_v2", value, "00000100");
        check("c_wrap", wrap, 1'b0);
        step();
        check("c_done", done, 1'b1);
        check("c_dvalid", out_valid, 1'b0);
        check("c_dvalue", value, "00000101");
        step();
        check("c_done_clr", {done, busy}, 2'b00);

        // Full rollover up
        kick("99999999", 2, 1'b0);
        check("w_v0", value, "99999999");
        check("w_w0", wrap, 1'b0);
        step();
        check("w_v1", value, "00000000");
        check("w_w1", wrap, 1'b1);
        step();
        check("w_w2", wrap, 1'b0);
        check("w_done", done, 1'b1);
        step();

`ifdef ASCII_STREAM_DOWN_EN
        kick("00001000", 2, 1'b1);
        check("d_v0", value, "00001000");
        step();
        check("d_v1", value, "00000999");
        step();
        check("d_done", done, 1'b1);
        step();
        kick("00000000", 1, 1'b1);
        check("dw_v0", value, "00000000");
        step();
        check("dw_v1", value, "99999999");
        check("dw_wrap", wrap, 1'b1);
        check("dw_done", done, 1'b1);
        step();
`else
        kick("00001000", 2, 1'b1);
        check("u_v0", value, "00001000");
        step();
        check("u_v1", value, "00001001");
        step();
        check("u_done", done, 1'b1);
        step();
`endif

        // Backpressure: ready 1,0,0,1
        hs_cnt = 0;
        kick("00000010", 2, 1'b0);
        out_ready = 1'b1;
        check("b_v0", value, "00000010");
        step();
        out_ready = 1'b0;
        check("b_v1", {out_valid, value}, {1'b1, 64'("00000011")});
        step();
        check("b_s1", {out_valid, value}, {1'b1, 64'("00000011")});
        step();
        check("b_s2", {out_valid, value}, {1'b1, 64'("00000011")});
        out_ready = 1'b1;
        step();
        check("b_done", done, 1'b1);
        check("b_value", value, "00000012");
        check("b_hs", 64'(hs_cnt), 64'd2);
        step();

        // Bad digit and zero length
        kick("12A45678", 0, 1'b0);
        check("e_value", value, "12045678");
        check("e_err", load_err, 1'b1);
        check("e_valid", out_valid, 1'b0);
        check("e_done", done, 1'b1);
        step();
        check("e_idle", {done, busy}, 2'b00);
        check("e_sticky", load_err, 1'b1);

        // Abort on the last handshake
        kick("00000050", 2, 1'b0);
        check("a_err_clr", load_err, 1'b0);
        check("a_v0", value, "00000050");
        step();
        check("a_v1", value, "00000051");
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("a_state", {done, busy, out_valid}, 3'b000);
        check("a_hold", value, "00000051");
        step();
        check("a_nodone", done, 1'b0);

        // Asynchronous reset mid-burst
        kick("00000777", 5, 1'b0);
        step();
        check("r_pre", value, "00000778");
        reset_n = 1'b0;
        #1;
        check("r_valid", out_valid, 1'b0);
        check("r_value", value, "00000000");
        check("r_busy", busy, 1'b0);
        #3;
        reset_n = 1'b1;
        step();
        check("r_after", {out_valid, done}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ascii_dec_stream.md
# ascii_dec_stream

Parametrised ASCII-decimal sequence generator for the password/hash test datapath. Loads a DIGITS-wide ASCII decimal string, then streams LENGTH consecutive values over a valid/ready interface, counting up or down with ripple carry/borrow across digits. It sits between the test controller and the hash core and generalises the fixed 8-digit, up-only `next`-stepped counter. It adds the following over that counter:

- a width parameter
- a down mode
- a burst length
- handshaking
- abort
- wrap and error reporting

## Interface
Parameters:
- DIGITS, 8, number of ASCII digits; value width is 8*DIGITS, MSB byte is the most significant digit
- CW, 32, width of the burst-length counter

Ports:
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  reset, asynchronous and active-low
- start  in  1  one-cycle request; sampled only in IDLE
- start_data  in  8*DIGITS  initial ASCII value, captured on accepted start
- length  in  CW  number of values to emit, captured on accepted start
- down  in  1  count direction, captured on accepted start (1 = decrement)
- abort  in  1  return to IDLE, highest priority after reset
- out_valid  out  1  value is valid
- out_ready  in  1  consumer accepts value
- value  out  8*DIGITS  current ASCII decimal value
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse after the last value is accepted
- wrap  out  1  one-cycle pulse: the last step rolled over all digits
- load_err  out  1  sticky until next accepted start: start_data had a non-digit byte

## Operation
- States:
  - IDLE: waits for start.
  - RUN: streams values.
  - DONE: one cycle, then returns to IDLE.
- IDLE and start:
  - If length != 0: capture direction, load value from start_data with each byte outside "0".."9" replaced by "0", set load_err if any byte was replaced, set remaining = length, go to RUN.
  - If length == 0: perform the same load, but go straight to DONE and emit no values.
- RUN:
  - out_valid = 1 throughout RUN.
  - Handshake = out_valid & out_ready.
  - On handshake: value steps by one in the captured direction and remaining decrements.
  - If remaining was 1 at the handshake: go to DONE.
- DONE: out_valid = 0, done = 1, then IDLE. value keeps the stepped value.
- Digit arithmetic, up:
  - Digit i becomes "0" if it and all lower digits are "9".
  - Otherwise digit i increments if all lower digits are "9".
  - Otherwise digit i holds.
- Digit arithmetic, down: same rule with "0" in place of "9" and "9" in place of "0", decrementing.
- Full rollover:
  - All "9" stepping up gives all "0", and wrap pulses.
  - All "0" stepping down gives all "9", and wrap pulses.
- start in RUN or DONE: ignored.
- Changes to down/length/start_data after an accepted start: no effect.
- abort in any state:
  - Next state is IDLE and out_valid drops.
  - value holds, done is not pulsed, load_err holds.
- Simultaneous abort and handshake on the last value: abort wins, no done.

## Timing
- Reset values:
  - state IDLE; value all "0" (8'h30 per byte)
  - out_valid 0, busy 0, done 0, wrap 0, load_err 0, remaining 0
- start accepted at edge t: the loaded value and out_valid = 1 are visible after edge t (cycle t+1).
- One value per cycle at full throughput with out_ready held high.
- Backpressure: value and out_valid stay stable while out_valid & !out_ready.
- wrap: asserted in the cycle after the handshake that rolled over, coincident with the new value.
- done: asserted in the cycle after the last handshake, for exactly one cycle.
- Async reset mid-burst: all outputs return to their reset values immediately, with no handshake completing.

## Configuration
- `ASCII_STREAM_DOWN_EN` defined: the down port is honoured as described above.
- Undefined: the down port remains but is ignored, the counter is up-only, and the borrow logic is not synthesised.

## Structure
- Package ascii_stream_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - constants ASCII_ZERO = 8'h30 and ASCII_NINE = 8'h39
  - an is_digit function
- Sub-module ascii_digit_cell: one digit plus its carry/borrow.
  - Inputs: digit, direction, all-lower-saturated.
  - Outputs: next digit and saturated flag.
  - Instantiated DIGITS times in a generate loop; carry is chained as a saturated-AND from the LSB upward.

## Test plan
- DIGITS=8, start_data "00000098", length 3, up, out_ready = 1 → values "00000098", "00000099", "00000100", then done for 1 cycle; wrap stays 0.
- start_data "99999999", length 2, up → "99999999", then "00000000" with wrap = 1 in that cycle.
- With `ASCII_STREAM_DOWN_EN`, start_data "00001000", length 2, down=1 → "00001000", "00000999"; all "0" down → all "9" with wrap.
- Backpressure: out_ready toggled 1,0,0,1 → value and out_valid stable across the stalled cycles; exactly length handshakes occur.
- start_data "12A45678" → loaded value "12045678" and load_err = 1; length 0 → no out_valid, done after 1 cycle.
- abort on the last handshake → no done, IDLE next cycle; reset_n low mid-burst → out_valid 0 and value all "0" asynchronously.
